// File: rtl/si570_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | si570_pkg : shared types and register constants for the sequencer  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package si570_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WAIT_RSP = 3'd2,
      ST_DONE     = 3'd3,
      ST_ERR      = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      STEP_MUX      = 3'd0,
      STEP_FREEZE   = 3'd1,
      STEP_WR_A     = 3'd2,
      STEP_WR_B     = 3'd3,
      STEP_UNFREEZE = 3'd4,
      STEP_NEWFREQ  = 3'd5,
      STEP_POLL     = 3'd6
   } step_t;

   localparam logic [7:0] REG_HS_N1   = 8'd7;
   localparam logic [7:0] REG_RFREQ_B = 8'd10;
   localparam logic [7:0] REG_FREEZE  = 8'd137;
   localparam logic [7:0] REG_CTRL    = 8'd135;

   localparam logic [7:0] FREEZE_DCO   = 8'h10;
   localparam logic [7:0] NEW_FREQ     = 8'h40;
   localparam int         NEW_FREQ_BIT = 6;

endpackage
`default_nettype wire

// File: rtl/si570_txn_rom.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | si570_txn_rom : maps step index + latched settings to rv0 fields   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module si570_txn_rom
   import si570_pkg::*;
#(
   parameter logic [6:0] MUX_ADDR    = 7'h74,
   parameter logic [7:0] MUX_CHANNEL = 8'h01,
   parameter logic [6:0] SI570_ADDR  = 7'h5D
)
(
   input  step_t            i_step,
   input  logic [2:0]       i_hs_div,
   input  logic [6:0]       i_n1,
   input  logic [37:0]      i_rfreq,
   output logic [6:0]       o_slave_address,
   output logic [3:0][7:0]  o_wdata,
   output logic [1:0]       o_burst_count_wr,
   output logic [1:0]       o_burst_count_rd,
   output logic             o_rd_wrn
);

   always_comb begin
      o_slave_address  = SI570_ADDR;
      o_wdata          = '0;
      o_burst_count_wr = 2'd0;
      o_burst_count_rd = 2'd0;
      o_rd_wrn         = 1'b0;
      case (i_step)
         STEP_MUX: begin
            o_slave_address = MUX_ADDR;
            o_wdata[0]      = MUX_CHANNEL;
         end
         STEP_FREEZE: begin
            o_burst_count_wr = 2'd1;
            o_wdata[0]       = REG_FREEZE;
            o_wdata[1]       = FREEZE_DCO;
         end
         // Registers 7..12 are one big-endian field: HS_DIV, N1, RFREQ
         STEP_WR_A: begin
            o_burst_count_wr = 2'd3;
            o_wdata[0]       = REG_HS_N1;
            o_wdata[1]       = {i_hs_div, i_n1[6:2]};
            o_wdata[2]       = {i_n1[1:0], i_rfreq[37:32]};
            o_wdata[3]       = i_rfreq[31:24];
         end
         STEP_WR_B: begin
            o_burst_count_wr = 2'd3;
            o_wdata[0]       = REG_RFREQ_B;
            o_wdata[1]       = i_rfreq[23:16];
            o_wdata[2]       = i_rfreq[15:8];
            o_wdata[3]       = i_rfreq[7:0];
         end
         STEP_UNFREEZE: begin
            o_burst_count_wr = 2'd1;
            o_wdata[0]       = REG_FREEZE;
         end
         STEP_NEWFREQ: begin
            o_burst_count_wr = 2'd1;
            o_wdata[0]       = REG_CTRL;
            o_wdata[1]       = NEW_FREQ;
         end
         STEP_POLL: begin
            o_rd_wrn   = 1'b1;
            o_wdata[0] = REG_CTRL;
         end
         default: begin
            o_slave_address = 7'd0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/si570_freq_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | si570_freq_sequencer : programs the Si570 to a new frequency over  |
// | the i2c_master rv0/rv1 channels from a single start pulse          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module si570_freq_sequencer
   import si570_pkg::*;
#(
   parameter logic [6:0] MUX_ADDR    = 7'h74,
   parameter logic [7:0] MUX_CHANNEL = 8'h01,
   parameter logic [6:0] SI570_ADDR  = 7'h5D,
   parameter int         MAX_POLLS   = 16
)
(
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic [2:0]      i_hs_div,
   input  logic [6:0]      i_n1,
   input  logic [37:0]     i_rfreq,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_error,
   output logic [2:0]      o_fail_step,
   output logic            o_rv0_valid,
   input  logic            i_rv0_ready,
   output logic [6:0]      o_rv0_slave_address,
   output logic [3:0][7:0] o_rv0_wdata,
   output logic [1:0]      o_rv0_burst_count_wr,
   output logic [1:0]      o_rv0_burst_count_rd,
   output logic            o_rv0_rd_wrn,
   input  logic            i_rv1_valid,
   output logic            o_rv1_ready,
   input  logic [3:0][7:0] i_rv1_rdata,
   input  logic            i_rv1_nack
);

   localparam int PCW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;

   state_t           r_state, w_state_nxt;
   step_t            r_step, w_step_nxt;
   logic [PCW-1:0]   r_poll_cnt, w_poll_nxt;
   logic [2:0]       r_hs_div;
   logic [6:0]       r_n1;
   logic [37:0]      r_rfreq;
   logic             r_error, w_error_nxt;
   logic [2:0]       r_fail_step, w_fail_nxt;
   logic             w_latch;
   logic             w_issue;
   logic [6:0]       w_addr;
   logic [3:0][7:0]  w_wdata;
   logic [1:0]       w_bwr, w_brd;
   logic             w_rd_wrn;
   logic             w_unused_rdata;

   assign w_unused_rdata = ^i_rv1_rdata;

   si570_txn_rom #(
      .MUX_ADDR    (MUX_ADDR),
      .MUX_CHANNEL (MUX_CHANNEL),
      .SI570_ADDR  (SI570_ADDR)
   ) u_rom (
      .i_step           (r_step),
      .i_hs_div         (r_hs_div),
      .i_n1             (r_n1),
      .i_rfreq          (r_rfreq),
      .o_slave_address  (w_addr),
      .o_wdata          (w_wdata),
      .o_burst_count_wr (w_bwr),
      .o_burst_count_rd (w_brd),
      .o_rd_wrn         (w_rd_wrn)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_step      <= STEP_MUX;
         r_poll_cnt  <= '0;
         r_hs_div    <= '0;
         r_n1        <= '0;
         r_rfreq     <= '0;
         r_error     <= 1'b0;
         r_fail_step <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_step      <= w_step_nxt;
         r_poll_cnt  <= w_poll_nxt;
         r_error     <= w_error_nxt;
         r_fail_step <= w_fail_nxt;
         if (w_latch) begin
            r_hs_div <= i_hs_div;
            r_n1     <= i_n1;
            r_rfreq  <= i_rfreq;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_poll_nxt  = r_poll_cnt;
      w_error_nxt = r_error;
      w_fail_nxt  = r_fail_step;
      w_latch     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_latch     = 1'b1;
               w_step_nxt  = STEP_MUX;
               w_poll_nxt  = '0;
               w_error_nxt = 1'b0;
               w_fail_nxt  = '0;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (i_rv0_ready) w_state_nxt = ST_WAIT_RSP;
         end
         ST_WAIT_RSP: begin
            if (i_rv1_valid) begin
               if (i_rv1_nack) begin
                  w_state_nxt = ST_ERR;
                  w_error_nxt = 1'b1;
                  w_fail_nxt  = r_step;
               end else if (r_step < STEP_POLL) begin
                  w_step_nxt  = step_t'(r_step + 3'd1);
                  w_state_nxt = ST_ISSUE;
               end else if (!i_rv1_rdata[0][NEW_FREQ_BIT]) begin
                  w_state_nxt = ST_DONE;
               end else if (r_poll_cnt < PCW'(MAX_POLLS - 1)) begin
                  w_poll_nxt  = r_poll_cnt + 1'b1;
                  w_state_nxt = ST_ISSUE;
               end else begin
                  w_state_nxt = ST_ERR;
                  w_error_nxt = 1'b1;
                  w_fail_nxt  = STEP_POLL;
               end
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         ST_ERR:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Fields are zeroed outside ISSUE so reset really leaves every output at 0
   assign w_issue              = (r_state == ST_ISSUE);
   assign o_rv0_valid          = w_issue;
   assign o_rv0_slave_address  = w_issue ? w_addr   : '0;
   assign o_rv0_wdata          = w_issue ? w_wdata  : '0;
   assign o_rv0_burst_count_wr = w_issue ? w_bwr    : '0;
   assign o_rv0_burst_count_rd = w_issue ? w_brd    : '0;
   assign o_rv0_rd_wrn         = w_issue ? w_rd_wrn : 1'b0;
   assign o_rv1_ready          = (r_state == ST_WAIT_RSP);
   assign o_busy               = w_issue || (r_state == ST_WAIT_RSP);
   assign o_done               = (r_state == ST_DONE);
   assign o_error              = r_error;
   assign o_fail_step          = r_fail_step;

endmodule
`default_nettype wire

// File: tb/tb_si570_freq_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_si570_freq_sequencer : directed + randomized bench with an      |
// | I2C-master BFM and a transaction-level reference model             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_si570_freq_sequencer;

   localparam int         MAX_POLLS = 4;
   localparam logic [6:0] MUX_ADDR  = 7'h74;
   localparam logic [7:0] MUX_CH    = 8'h01;
   localparam logic [6:0] SI_ADDR   = 7'h5D;
   localparam int         ALWAYS    = 1000;

   typedef struct packed {
      logic [6:0]  addr;
      logic        rd_wrn;
      logic [1:0]  wr;
      logic [1:0]  rd;
      logic [31:0] wdata;
   } req_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [2:0]      hs_in = '0;
   logic [6:0]      n1_in = '0;
   logic [37:0]     rf_in = '0;
   logic            rv0_ready = 1'b0;
   logic            rv1_valid = 1'b0;
   logic [3:0][7:0] rv1_rdata = '0;
   logic            rv1_nack = 1'b0;

   logic            o_busy, o_done, o_error, o_rv0_valid, o_rv0_rd_wrn, o_rv1_ready;
   logic [2:0]      o_fail_step;
   logic [6:0]      o_rv0_slave_address;
   logic [3:0][7:0] o_rv0_wdata;
   logic [1:0]      o_rv0_burst_count_wr, o_rv0_burst_count_rd;

   int              n_checks = 0;
   int              n_pass = 0;
   int              n_fail = 0;
   logic [31:0]     w2_obs, w3_obs;

   si570_freq_sequencer #(
      .MUX_ADDR    (MUX_ADDR),
      .MUX_CHANNEL (MUX_CH),
      .SI570_ADDR  (SI_ADDR),
      .MAX_POLLS   (MAX_POLLS)
   ) dut (
      .i_clk                (clk),
      .i_rst_n              (rst_n),
      .i_start              (start),
      .i_hs_div             (hs_in),
      .i_n1                 (n1_in),
      .i_rfreq              (rf_in),
      .o_busy               (o_busy),
      .o_done               (o_done),
      .o_error              (o_error),
      .o_fail_step          (o_fail_step),
      .o_rv0_valid          (o_rv0_valid),
      .i_rv0_ready          (rv0_ready),
      .o_rv0_slave_address  (o_rv0_slave_address),
      .o_rv0_wdata          (o_rv0_wdata),
      .o_rv0_burst_count_wr (o_rv0_burst_count_wr),
      .o_rv0_burst_count_rd (o_rv0_burst_count_rd),
      .o_rv0_rd_wrn         (o_rv0_rd_wrn),
      .i_rv1_valid          (rv1_valid),
      .o_rv1_ready          (o_rv1_ready),
      .i_rv1_rdata          (rv1_rdata),
      .i_rv1_nack           (rv1_nack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: the frequency word is one 48-bit big-endian value spread over regs 7..12
   function automatic req_t exp_req(input int step, input logic [2:0] hs,
                                    input logic [6:0] n1, input logic [37:0] rf);
      req_t        r;
      logic [47:0] fw;
      logic [7:0]  b [4];
      fw = {hs, n1, rf};
      for (int k = 0; k < 4; k++) b[k] = 8'h00;
      r.addr   = SI_ADDR;
      r.rd_wrn = 1'b0;
      r.rd     = 2'd0;
      r.wr     = 2'd0;
      case (step)
         0: begin r.addr = MUX_ADDR; b[0] = MUX_CH; end
         1: begin r.wr = 2'd1; b[0] = 8'd137; b[1] = 8'h10; end
         2: begin r.wr = 2'd3; b[0] = 8'd7;  b[1] = fw[47:40]; b[2] = fw[39:32]; b[3] = fw[31:24]; end
         3: begin r.wr = 2'd3; b[0] = 8'd10; b[1] = fw[23:16]; b[2] = fw[15:8];  b[3] = fw[7:0]; end
         4: begin r.wr = 2'd1; b[0] = 8'd137; end
         5: begin r.wr = 2'd1; b[0] = 8'd135; b[1] = 8'h40; end
         default: begin r.rd_wrn = 1'b1; b[0] = 8'd135; end
      endcase
      r.wdata = {b[3], b[2], b[1], b[0]};
      return r;
   endfunction

   function automatic req_t cur_req();
      return req_t'({o_rv0_slave_address, o_rv0_rd_wrn, o_rv0_burst_count_wr,
                     o_rv0_burst_count_rd, o_rv0_wdata});
   endfunction

   // busy_polls: poll responses with NewFreq still set before it clears
   // nack_idx / bp_idx / abort_idx: request position (0-based), -1 = none
   task automatic run_txn(input logic [2:0] hs, input logic [6:0] n1, input logic [37:0] rf,
                          input int busy_polls, input int nack_idx, input int bp_idx,
                          input int bp_cycles, input int abort_idx);
      int   steps[$];
      int   n_poll, exp_fail, poll_no;
      bit   exp_err, any_valid;
      req_t obs, first;

      steps = {0, 1, 2, 3, 4, 5};
      n_poll = (busy_polls < MAX_POLLS) ? busy_polls + 1 : MAX_POLLS;
      for (int k = 0; k < n_poll; k++) steps.push_back(6);
      exp_err  = (busy_polls >= MAX_POLLS);
      exp_fail = 6;
      if (nack_idx >= 0 && nack_idx < steps.size()) begin
         while (steps.size() > nack_idx + 1) void'(steps.pop_back());
         exp_err  = 1'b1;
         exp_fail = steps[nack_idx];
      end

      @(negedge clk);
      start = 1'b1; hs_in = hs; n1_in = n1; rf_in = rf;
      @(negedge clk);
      start = 1'b0;
      hs_in = 3'($urandom); n1_in = 7'($urandom); rf_in = {6'($urandom), 32'($urandom)};
      check("busy_after_start", o_busy, 1);
      check("error_cleared", o_error, 0);
      check("fail_step_cleared", o_fail_step, 0);

      poll_no = 0;
      for (int i = 0; i < steps.size(); i++) begin
         check($sformatf("rv0_valid[%0d]", i), o_rv0_valid, 1);
         obs = cur_req();
         check($sformatf("req[%0d] step%0d", i, steps[i]), obs, exp_req(steps[i], hs, n1, rf));
         if (steps[i] == 2) w2_obs = obs.wdata;
         if (steps[i] == 3) w3_obs = obs.wdata;
         if (i == abort_idx) return;
         if (i == bp_idx) begin
            first = obs;
            repeat (bp_cycles) begin
               start = ($urandom_range(0, 3) == 0);
               @(negedge clk);
               check("bp_valid_held", o_rv0_valid, 1);
               check("bp_fields_stable", cur_req(), first);
            end
            start = 1'b0;
         end
         rv0_ready = 1'b1;
         @(negedge clk);
         rv0_ready = 1'b0;
         check("valid_dropped", o_rv0_valid, 0);
         check("rv1_ready_waiting", o_rv1_ready, 1);
         rv1_valid = 1'b1;
         rv1_nack  = (i == nack_idx);
         rv1_rdata = 32'($urandom);
         if (steps[i] == 6) begin
            rv1_rdata[0] = 8'($urandom) & 8'hBF;
            if (poll_no < busy_polls) rv1_rdata[0] = rv1_rdata[0] | 8'h40;
            poll_no++;
         end
         @(negedge clk);
         rv1_valid = 1'b0;
         rv1_nack  = 1'b0;
         check("rv1_ready_low_after", o_rv1_ready, 0);
      end

      check("done_pulse", o_done, !exp_err);
      check("busy_fell", o_busy, 0);
      check("error_flag", o_error, exp_err);
      if (exp_err) check("fail_step", o_fail_step, exp_fail);
      @(negedge clk);
      check("done_one_cycle", o_done, 0);
      check("error_sticky", o_error, exp_err);
      any_valid = 1'b0;
      repeat (6) begin
         any_valid |= o_rv0_valid;
         @(negedge clk);
      end
      check("no_extra_requests", any_valid, 0);
   endtask

   initial begin
      logic [2:0]  hs;
      logic [6:0]  n1;
      logic [37:0] rf;

      repeat (2) @(negedge clk);
      check("reset_outputs", {o_busy, o_done, o_error, o_fail_step, o_rv0_valid,
            o_rv0_slave_address, o_rv0_wdata, o_rv0_burst_count_wr,
            o_rv0_burst_count_rd, o_rv0_rd_wrn, o_rv1_ready}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Happy path with the reference settings
      run_txn(3'b001, 7'h07, 38'h02_BC01_1EB8, 0, -1, -1, 0, -1);
      check("happy_wdata_step2", w2_obs, 32'hBCC2_2107);
      check("happy_wdata_step3", w3_obs, 32'hB81E_010A);

      // Poll retry, timeout, NACK then restart
      run_txn(3'b010, 7'h11, 38'h01_2345_6789, 2, -1, -1, 0, -1);
      run_txn(3'b011, 7'h22, 38'h3F_FFFF_FFFF, ALWAYS, -1, -1, 0, -1);
      run_txn(3'b100, 7'h33, 38'h00_0000_0001, 0, 1, -1, 0, -1);
      run_txn(3'b001, 7'h07, 38'h02_BC01_1EB8, 0, -1, -1, 0, -1);

      // Backpressure on WR_A with stray start pulses
      run_txn(3'b101, 7'h55, 38'h2A_AAAA_5555, 1, -1, 2, 50, -1);

      // Randomized transactions
      for (int t = 0; t < 8; t++) begin
         hs = 3'($urandom); n1 = 7'($urandom); rf = {6'($urandom), 32'($urandom)};
         run_txn(hs, n1, rf, $urandom_range(0, MAX_POLLS + 1),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1,
                 $urandom_range(0, 6), $urandom_range(0, 5), -1);
      end

      // Asynchronous reset while step 3 is being offered
      run_txn(3'b110, 7'h6C, 38'h15_0F0F_F0F0, 0, -1, -1, 0, 3);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {o_busy, o_done, o_error, o_fail_step, o_rv0_valid,
            o_rv0_slave_address, o_rv0_wdata, o_rv0_burst_count_wr,
            o_rv0_burst_count_rd, o_rv0_rd_wrn, o_rv1_ready}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hs = 3'($urandom); n1 = 7'($urandom); rf = {6'($urandom), 32'($urandom)};
      run_txn(hs, n1, rf, 1, -1, -1, 0, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/si570_freq_sequencer.md
# si570_freq_sequencer

Runs in the i2c_clk domain and sits directly upstream of `i2c_master`, driving its rv0 request and rv1 response channels. It programs the VC707 Si570 user-clock oscillator to a new frequency with one start pulse:
- selects the bus-mux channel;
- freezes the DCO;
- writes HS_DIV/N1/RFREQ (regs 7–12);
- unfreezes the DCO and asserts NewFreq;
- polls reg 135 until NewFreq self-clears.

It replaces hand-issued UART register pokes plus `pulse_generator` for clock bring-up.

## Interface
Parameters:
- MuxAddr, 7'h74, I2C bus-mux slave address
- MuxChannel, 8'h01, mux control byte selecting the Si570 branch
- Si570Addr, 7'h5D, Si570 slave address
- MaxPolls, 16, maximum reads of reg 135 before timeout (≥1)

Ports (reset is asynchronous, active-low; one clock):
- i_clk  in  1  i2c_clk, the same clock as `i2c_master`
- i_rst_n  in  1  async active-low reset
- i_start  in  1  start request, sampled only in IDLE
- i_hs_div  in  3  Si570 HS_DIV code
- i_n1  in  7  Si570 N1 code
- i_rfreq  in  38  Si570 RFREQ
- o_busy  out  1  high from start acceptance until DONE/ERR exit
- o_done  out  1  one-cycle pulse on successful completion
- o_error  out  1  sticky failure flag, cleared on next accepted start
- o_fail_step  out  3  step index of the failure, valid while o_error=1
- o_rv0_valid / i_rv0_ready  out/in  1  request handshake
- o_rv0_slave_address  out  7
- o_rv0_wdata  out  4x8  byte [0] is sent first
- o_rv0_burst_count_wr / _rd  out  2  byte count minus 1
- o_rv0_rd_wrn  out  1  1 = write pointer, repeated start, then read
- i_rv1_valid / o_rv1_ready  in/out  1  response handshake
- i_rv1_rdata  in  4x8
- i_rv1_nack  in  1

## Operation
Steps (index: slave, rd_wrn, wr count, wdata):
- 0 MUX: MuxAddr, 0, 0, {MuxChannel}
- 1 FREEZE: Si570Addr, 0, 1, {137, 8'h10}
- 2 WR_A: Si570Addr, 0, 3, {7, {hs_div, n1[6:2]}, {n1[1:0], rfreq[37:32]}, rfreq[31:24]}
- 3 WR_B: Si570Addr, 0, 3, {10, rfreq[23:16], rfreq[15:8], rfreq[7:0]}
- 4 UNFREEZE: Si570Addr, 0, 1, {137, 8'h00}
- 5 NEWFREQ: Si570Addr, 0, 1, {135, 8'h40}
- 6 POLL: Si570Addr, 1, 0, {135}, rd count 0

Request fields and unused wdata bytes:
- rd count is 0 for every step.
- Unused wdata bytes are 8'h00.

Input capture:
- hs_div, n1 and rfreq are captured on start acceptance.
- Later input changes have no effect.

FSM states are IDLE, ISSUE, WAIT_RSP, DONE, ERR.
- IDLE: i_start=1 → latch inputs, step=0, poll_cnt=0, clear o_error → ISSUE.
- ISSUE: o_rv0_valid=1 with fields from step. On valid&ready → WAIT_RSP.
- WAIT_RSP: o_rv1_ready=1. On i_rv1_valid:
  - nack → ERR, o_fail_step=step.
  - step<6 → step+1, ISSUE.
  - step 6 and rdata[0][6]=0 → DONE.
  - step 6, bit 6 set, poll_cnt<MaxPolls-1 → poll_cnt+1, ISSUE.
  - Otherwise (poll timeout) → ERR, o_fail_step=6.
- DONE: o_done=1 for one cycle → IDLE.
- ERR: o_error=1 → IDLE; o_error stays high.
- i_start while busy is ignored.
- i_rv1_valid outside WAIT_RSP is ignored; o_rv1_ready stays 0 there.

## Timing
Reset values:
- All outputs are 0; state IDLE; step, poll_cnt and latched data are 0.

Start and request latency:
- Start sampled at edge N: o_busy=1 and o_rv0_valid=1 from N+1.

rv0 request rules:
- Once asserted, valid and all rv0 fields stay stable until the edge where ready=1. Valid drops the next cycle.
- No combinational path from i_rv0_ready to o_rv0_valid.
- Back-to-back steps: the response is accepted at edge M, and the next request's valid is high from M+1.

Completion:
- o_done pulses the cycle after the final response. o_busy falls in the same cycle.

Reset mid-operation:
- Async reset forces IDLE and drops valid/ready immediately.
- Recovery of `i2c_master` is its own reset's concern. The shared `rst` is tied to both.

## Structure
- The package `si570_pkg` holds:
  - the state enum;
  - the step enum (3 bits);
  - register constants REG_HS_N1=7, REG_RFREQ_B=10, REG_FREEZE=137, REG_CTRL=135;
  - byte constants FREEZE_DCO=8'h10, NEW_FREQ=8'h40, NEW_FREQ_BIT=6.
- One combinational sub-module, `si570_txn_rom`, maps step plus latched data to rv0 fields. The FSM and counters live in the top.

## Test plan
- Happy path:
  - Stimulus: hs_div=3'b001, n1=7'h07, rfreq=38'h02_BC01_1EB8; the BFM acks all steps and the poll returns 8'h00.
  - Required: step 2 wdata={07,21,C2,BC}; step 3 wdata={0A,01,1E,B8}; exactly 7 requests; o_done pulses once; o_error=0.
- Poll retry: poll returns 8'h40 twice, then 8'h00 → 9 requests total, then o_done.
- Timeout: with MaxPolls=4, poll always returns 8'h40 → 4 poll requests, then o_error=1 and o_fail_step=6.
- NACK: i_rv1_nack=1 on step 1 → o_error=1, o_fail_step=1, no further requests; a new i_start clears o_error and restarts at step 0.
- Backpressure: i_rv0_ready held low 50 cycles → valid and fields stable throughout; i_start pulses during busy are ignored.
- Reset mid-step 3: i_rst_n low asynchronously → all outputs 0 without a clock edge; a subsequent start runs from step 0.
